systolic_array_sequencer: RTL
=============================

Name: systolic_array_sequencer

Overview:
- Control FSM for the NxN systolic MAC array.
- Sequences each tile in order: weight preload (N rows), input streaming (num_rows rows), then drain of the skewed pipeline.
- Drives the array-wide shift, start and weight_en controls, and flags valid output rows at the bottom edge.
- Sits between the tile scheduler / operand FIFOs and the MAC grid.

Parameters:
- N, 4: array dimension (rows = columns).
- CNT_W, 16: width of the row-count input and internal counters.

Ports:
- CLK  in  1  system clock.
- nRST  in  1  synchronous active-low reset.
- start  in  1  begin a tile; sampled only in IDLE.
- num_rows  in  CNT_W  input rows in the tile; latched with start.
- stall  in  1  global freeze.
- weight_valid  in  1  weight row available.
- weight_ready  out  1  weight row accepted this cycle when weight_valid=1.
- input_valid  in  1  input row available.
- input_ready  out  1  input row accepted this cycle when input_valid=1.
- mac_ready  in  1  AND of all MAC value_ready (no op in flight).
- weight_en  out  1  array bus carries weights.
- MAC_shift  out  1  array-wide shift pulse.
- mac_start  out  1  MAC start pulse.
- out_valid  out  1  bottom-edge accumulate row valid this cycle.
- out_row  out  CNT_W  index of the valid output row.
- busy  out  1  not in IDLE.
- done  out  1  one-cycle tile-complete pulse.

Behaviour:
- Reset: on CLK edge with nRST=0, FSM goes to IDLE and all counters clear. All outputs are 0 in IDLE: weight_ready, input_ready, weight_en, MAC_shift, mac_start, out_valid, busy, done, and out_row=0. Reset mid-tile aborts the tile with no done pulse.
- All outputs are combinational from state, counters and inputs. No registered-output latency.
- stall=1: no shift, start, ready or valid; state and counters hold; busy is unaffected.
- States: IDLE, LOAD_W, COMPUTE, DRAIN, DONE.
- IDLE:
  - start=1 and stall=0: latch num_rows into rows_q and clear w_cnt/in_cnt/sh_cnt.
  - Go to LOAD_W, or to DONE if num_rows=0.
  - start while busy is ignored.
- LOAD_W:
  - weight_en=1 throughout; weight_ready=!stall.
  - On a weight handshake: MAC_shift=1, w_cnt++.
  - When w_cnt reaches N-1 and a handshake occurs: go to COMPUTE.
  - Takes exactly N handshakes.
- COMPUTE:
  - weight_en=0; input_ready=!stall & mac_ready.
  - On an input handshake: MAC_shift=1, mac_start=1, in_cnt++, sh_cnt++.
  - When the handshake with in_cnt=rows_q-1 occurs: go to DRAIN.
  - If N=1, the DRAIN bubble count is 0: go straight to DONE.
- DRAIN:
  - Issues 2N-2 bubble shifts, each on a cycle with mac_ready=1 and stall=0.
  - Each bubble shift: MAC_shift=1, mac_start=1, sh_cnt++. Zero operand on the input bus is the datapath's job.
  - After the last bubble: go to DONE.
- Output flagging:
  - On any shift cycle where sh_cnt (pre-increment) >= 2N-2: out_valid=1 and out_row = sh_cnt-(2N-2).
  - Row k (0-based) appears on shift k+2N-1 (1-based).
  - Exactly rows_q out_valid pulses per tile.
- DONE: done=1 and busy=1 for one cycle, then IDLE. A start in this cycle is ignored.
- Counter width:
  - sh_cnt needs CNT_W+1 bits so that rows_q+2N-2 never wraps.
  - rows_q = 2^CNT_W-1 must complete correctly.
- Simultaneous events: stall overrides valid, mac_ready and start. A weight_valid arriving while the FSM is not in LOAD_W is not accepted.

Decomposition:
- sys_arr_pkg:
  - Add sa_seq_state_t (enum for the five states).
  - Add constant DRAIN_SHIFTS = 2*N-2.
  - Reuse N/DW from the package where parameters default.
- Sub-module sa_skew_counter: holds the sh_cnt up-counter and the compare that generates out_valid/out_row. Instantiated once.

Test Plan (N=4):
- Basic tile: start, num_rows=3, valids held high, mac_ready=1.
  - 4 weight shifts with weight_en=1.
  - 3 compute shifts with mac_start=1.
  - 6 bubble shifts.
  - out_valid on total shifts 7, 8, 9 (out_row 0, 1, 2).
  - done in the cycle after the last shift, 14 cycles after start.
- Backpressure: weight_valid toggling 1010…
  - Exactly 4 weight handshakes; MAC_shift only on handshake cycles.
  - Then repeat with mac_ready low for 2 cycles mid-COMPUTE: input_ready=0 and no shift during those 2 cycles; total output count still 3.
- Stall freeze: stall=1 for 5 cycles inside DRAIN.
  - All pulses are 0 and sh_cnt/out_row hold.
  - Completion is delayed by exactly 5 cycles.
- Boundary num_rows=0: start -> DONE -> IDLE.
  - No MAC_shift, no out_valid.
  - done pulses exactly 1 cycle after start.
- Reset and start-ignore: nRST=0 mid-COMPUTE for 1 cycle.
  - Next cycle: all outputs 0, busy=0, no done.
  - A fresh tile then runs to completion.
  - start pulses during busy and during DONE are ignored.
- Wide count: CNT_W=4, num_rows=15.
  - 15 out_valid pulses with out_row 0..15-1.
  - sh_cnt reaches 21 without wrap.

Source files
------------

// File: rtl/systolic_array_sequencer_pkg.sv
// Shared constants, state encoding and helpers for the systolic array sequencer.
// The array dimension and count width here are the defaults for every block.
package sys_arr_pkg;

    localparam int N            = 4;
    localparam int DW           = 8;
    localparam int CNT_W        = 16;
    localparam int DRAIN_SHIFTS = 2*N-2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_W  = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } sa_seq_state_t;

    // Bubble shifts needed to flush the diagonal skew of an n x n array.
    function automatic int drain_shifts(input int n);
        return 2*n-2;
    endfunction

endpackage

// File: rtl/systolic_array_sequencer_if.sv
// Handshake and control bundle between the tile scheduler / operand FIFOs,
// the sequencer and the MAC grid.
interface systolic_array_sequencer_if #(
    parameter int CNT_W = sys_arr_pkg::CNT_W
);
    logic             start;
    logic [CNT_W-1:0] num_rows;
    logic             stall;
    logic             weight_valid;
    logic             weight_ready;
    logic             input_valid;
    logic             input_ready;
    logic             mac_ready;
    logic             weight_en;
    logic             MAC_shift;
    logic             mac_start;
    logic             out_valid;
    logic [CNT_W-1:0] out_row;
    logic             busy;
    logic             done;

    modport master (
        output start, num_rows, stall, weight_valid, input_valid, mac_ready,
        input  weight_ready, input_ready, weight_en, MAC_shift, mac_start,
               out_valid, out_row, busy, done
    );

    modport slave (
        input  start, num_rows, stall, weight_valid, input_valid, mac_ready,
        output weight_ready, input_ready, weight_en, MAC_shift, mac_start,
               out_valid, out_row, busy, done
    );

endinterface

// File: rtl/systolic_array_sequencer_skew_counter.sv
// Counts data/bubble shifts of a tile and flags which shifts carry a finished
// accumulate row out of the bottom edge of the skewed array.
module sa_skew_counter
    import sys_arr_pkg::*;
#(
    parameter int N     = sys_arr_pkg::N,
    parameter int CNT_W = sys_arr_pkg::CNT_W
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             clear_i,
    input  logic             shift_i,
    input  logic             active_i,
    input  logic [CNT_W-1:0] rows_i,
    output logic             out_valid_o,
    output logic [CNT_W-1:0] out_row_o,
    output logic             last_o
);

    localparam int DRAIN_SH = drain_shifts(N);
    localparam int SW       = CNT_W + 2;

    // One extra bit so rows + drain bubbles never wraps for a full-width row count.
    logic [CNT_W:0]  sh_cnt_q, sh_cnt_d;
    logic [SW-1:0]   sh_ext;
    logic [SW-1:0]   total;
    logic            reached;

    always_comb begin
        sh_ext  = SW'(sh_cnt_q);
        total   = SW'(rows_i) + SW'(DRAIN_SH);
        reached = (sh_ext >= SW'(DRAIN_SH));
        last_o  = ((sh_ext + SW'(1)) == total);

        sh_cnt_d = sh_cnt_q;
        if (clear_i) begin
            sh_cnt_d = '0;
        end else if (shift_i) begin
            sh_cnt_d = sh_cnt_q + (CNT_W+1)'(1);
        end

        out_valid_o = shift_i & reached;
        out_row_o   = (active_i && reached) ? CNT_W'(sh_ext - SW'(DRAIN_SH)) : '0;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            sh_cnt_q <= '0;
        end else begin
            sh_cnt_q <= sh_cnt_d;
        end
    end

endmodule

// File: rtl/systolic_array_sequencer.sv
// Tile sequencer for the NxN systolic MAC array: weight preload, input
// streaming and skew drain, with bottom-edge output row flagging.
module systolic_array_sequencer
    import sys_arr_pkg::*;
#(
    parameter int N     = sys_arr_pkg::N,
    parameter int CNT_W = sys_arr_pkg::CNT_W
) (
    input  logic                        CLK,
    input  logic                        nRST,
    systolic_array_sequencer_if.slave   bus
);

    localparam int         DRAIN_SH  = drain_shifts(N);
    localparam logic [2:0] S_IDLE    = ST_IDLE;
    localparam logic [2:0] S_LOAD_W  = ST_LOAD_W;
    localparam logic [2:0] S_COMPUTE = ST_COMPUTE;
    localparam logic [2:0] S_DRAIN   = ST_DRAIN;
    localparam logic [2:0] S_DONE    = ST_DONE;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] rows_q, rows_d;
    logic [CNT_W-1:0] w_cnt_q, w_cnt_d;
    logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
    logic             w_hs, in_hs, bubble, accept, last_sh;

    // Stall masks every handshake, bubble and start acceptance.
    always_comb begin
        w_hs   = (state_q == S_LOAD_W)  & ~bus.stall & bus.weight_valid;
        in_hs  = (state_q == S_COMPUTE) & ~bus.stall & bus.mac_ready & bus.input_valid;
        bubble = (state_q == S_DRAIN)   & ~bus.stall & bus.mac_ready;
        accept = (state_q == S_IDLE)    & ~bus.stall & bus.start;
    end

    always_comb begin
        state_d  = state_q;
        rows_d   = rows_q;
        w_cnt_d  = w_cnt_q;
        in_cnt_d = in_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    rows_d   = bus.num_rows;
                    w_cnt_d  = '0;
                    in_cnt_d = '0;
                    state_d  = (bus.num_rows == '0) ? S_DONE : S_LOAD_W;
                end
            end
            S_LOAD_W: begin
                if (w_hs) begin
                    w_cnt_d = w_cnt_q + CNT_W'(1);
                    if (w_cnt_q == CNT_W'(N-1)) begin
                        state_d = S_COMPUTE;
                    end
                end
            end
            S_COMPUTE: begin
                if (in_hs) begin
                    in_cnt_d = in_cnt_q + CNT_W'(1);
                    if (in_cnt_q == rows_q - CNT_W'(1)) begin
                        state_d = (DRAIN_SH == 0) ? S_DONE : S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (bubble && last_sh) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!bus.stall) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q  <= S_IDLE;
            rows_q   <= '0;
            w_cnt_q  <= '0;
            in_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            rows_q   <= rows_d;
            w_cnt_q  <= w_cnt_d;
            in_cnt_q <= in_cnt_d;
        end
    end

    sa_skew_counter #(
        .N     (N),
        .CNT_W (CNT_W)
    ) u_skew (
        .CLK         (CLK),
        .nRST        (nRST),
        .clear_i     (accept),
        .shift_i     (in_hs | bubble),
        .active_i    (state_q != S_IDLE),
        .rows_i      (rows_q),
        .out_valid_o (bus.out_valid),
        .out_row_o   (bus.out_row),
        .last_o      (last_sh)
    );

    assign bus.weight_en    = (state_q == S_LOAD_W);
    assign bus.weight_ready = (state_q == S_LOAD_W) & ~bus.stall;
    assign bus.input_ready  = (state_q == S_COMPUTE) & ~bus.stall & bus.mac_ready;
    assign bus.MAC_shift    = w_hs | in_hs | bubble;
    assign bus.mac_start    = in_hs | bubble;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.done         = (state_q == S_DONE) & ~bus.stall;

endmodule
